pc_gen: RTL and testbench

//  Parametrised fetch-stage program-counter generator for the pipelined CPU, the next generation of the basic PC register.

---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_redirect_buf.sv | 36 +++
 rtl/pc_gen.sv | 132 +++++++++++++
 tb/tb_pc_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared constants and FSM encoding for the fetch-stage PC generator
package pc_gen_pkg;

  // Reset level and instruction-ROM chip-enable levels
  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Default instruction address bus width
  localparam int INST_ADDR_BUS = 32;

  // Boot / running / stalled fetch states
  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_HOLD = 2'd2
  } pcg_state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - one-entry buffer holding a redirect raised while fetch is stalled
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_BUS
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_set,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_pend_valid,
  output logic [ADDR_W-1:0] o_pend_addr
);

  logic              r_pend_valid;
  logic [ADDR_W-1:0] r_pend_addr;

  // Clear beats set so an exception or applied redirect always empties the entry;
  // a set while already full overwrites, so the youngest branch wins.
  always_ff @(posedge i_clk) begin
    if (i_rst == RST_ENABLE) begin
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
    end else if (i_clr) begin
      r_pend_valid <= 1'b0;
    end else if (i_set) begin
      r_pend_valid <= 1'b1;
      r_pend_addr  <= i_addr;
    end
  end

  assign o_pend_valid = r_pend_valid;
  assign o_pend_addr  = r_pend_addr;

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter with boot, stall, branch and exception redirect
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W     = INST_ADDR_BUS,
  parameter int                INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(32'h00000020)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_branch_flag,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_exc_flag,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_inst_mem_en,
  output logic              o_pc_valid
);

  localparam logic [ADDR_W-1:0] INC_STEP   = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));

  pcg_state_t        r_state;
  pcg_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic              r_inst_mem_en;
  logic              r_pc_valid;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              w_inst_mem_en_nxt;
  logic              w_pc_valid_nxt;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_branch_aligned;
  logic              w_pend_set;
  logic              w_pend_clr;
  logic              w_pend_valid;
  logic [ADDR_W-1:0] w_pend_addr;

  assign w_pc_inc         = r_pc + INC_STEP;
  assign w_branch_aligned = i_branch_target & ALIGN_MASK;

  pc_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_buf (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_set        (w_pend_set),
    .i_clr        (w_pend_clr),
    .i_addr       (w_branch_aligned),
    .o_pend_valid (w_pend_valid),
    .o_pend_addr  (w_pend_addr)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst == RST_ENABLE) r_state <= PCG_BOOT;
    else                     r_state <= w_state_nxt;
  end

  // Next state: only a stall without a higher-priority redirect parks the FSM in HOLD
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PCG_BOOT: w_state_nxt = PCG_RUN;
      PCG_RUN, PCG_HOLD: begin
        if (i_exc_flag)                       w_state_nxt = PCG_RUN;
        else if (i_branch_flag && !i_stall)   w_state_nxt = PCG_RUN;
        else if (i_stall)                     w_state_nxt = PCG_HOLD;
        else                                  w_state_nxt = PCG_RUN;
      end
      default: w_state_nxt = PCG_BOOT;
    endcase
  end

  // Next pc / enable / valid and pending-buffer control, priority exc > branch > stall > increment
  always_comb begin
    w_pc_nxt          = r_pc;
    w_inst_mem_en_nxt = r_inst_mem_en;
    w_pc_valid_nxt    = r_pc_valid;
    w_pend_set        = 1'b0;
    w_pend_clr        = 1'b0;
    case (r_state)
      PCG_BOOT: begin
        w_pc_nxt          = RESET_PC;
        w_inst_mem_en_nxt = CHIP_ENABLE;
        w_pc_valid_nxt    = 1'b1;
      end
      PCG_RUN, PCG_HOLD: begin
        if (i_exc_flag) begin
          w_pc_nxt       = EXC_VEC;
          w_pc_valid_nxt = 1'b0;
          w_pend_clr     = 1'b1;
        end else if (i_branch_flag && !i_stall) begin
          w_pc_nxt       = w_branch_aligned;
          w_pc_valid_nxt = 1'b0;
          w_pend_clr     = 1'b1;
        end else if (i_stall) begin
          w_pend_set = i_branch_flag;
        end else if (w_pend_valid) begin
          // Stall just released with a buffered redirect: take it with no extra cycle
          w_pc_nxt       = w_pend_addr;
          w_pc_valid_nxt = 1'b0;
          w_pend_clr     = 1'b1;
        end else begin
          w_pc_nxt       = w_pc_inc;
          w_pc_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_pc_nxt = r_pc;
      end
    endcase
  end

  // Output registers, so nothing combinational reaches the ROM or IF/ID
  always_ff @(posedge i_clk) begin
    if (i_rst == RST_ENABLE) begin
      r_pc          <= RESET_PC;
      r_inst_mem_en <= CHIP_DISABLE;
      r_pc_valid    <= 1'b0;
    end else begin
      r_pc          <= w_pc_nxt;
      r_inst_mem_en <= w_inst_mem_en_nxt;
      r_pc_valid    <= w_pc_valid_nxt;
    end
  end

  assign o_pc          = r_pc;
  assign o_inst_mem_en = r_inst_mem_en;
  assign o_pc_valid    = r_pc_valid;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, branch, exc;
  logic [31:0] target;
  logic [31:0] pc;
  logic        en, valid;

  logic        rst8, stall8, branch8, exc8;
  logic [7:0]  target8;
  logic [7:0]  pc8;
  logic        en8, valid8;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_gen u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_stall         (stall),
    .i_branch_flag   (branch),
    .i_branch_target (target),
    .i_exc_flag      (exc),
    .o_pc            (pc),
    .o_inst_mem_en   (en),
    .o_pc_valid      (valid)
  );

  pc_gen #(
    .ADDR_W     (8),
    .INST_BYTES (4),
    .RESET_PC   (8'hF8),
    .EXC_VEC    (8'h20)
  ) u_dut8 (
    .i_clk           (clk),
    .i_rst           (rst8),
    .i_stall         (stall8),
    .i_branch_flag   (branch8),
    .i_branch_target (target8),
    .i_exc_flag      (exc8),
    .o_pc            (pc8),
    .o_inst_mem_en   (en8),
    .o_pc_valid      (valid8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8; exp_seq[3] = 32'hC;
    rst = 1'b1; stall = 1'b1; branch = 1'b1; exc = 1'b1; target = 32'h55;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (pc !== 32'h0 || en !== 1'b0 || valid !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_state cyc%0d pc=%h en=%b valid=%b required pc=0 en=0 valid=0", i, pc, en, valid);
      end
    end
    // Flags are still high on the boot cycle and must be ignored there
    rst = 1'b0;
    tick();
    stall = 1'b0; branch = 1'b0; exc = 1'b0;
    n_checks++;
    if (pc !== 32'h0 || en !== 1'b1 || valid !== 1'b1) begin
      n_errors++;
      $display("FAIL boot_first_fetch pc=%h en=%b valid=%b required pc=0 en=1 valid=1", pc, en, valid);
    end
    for (int i = 1; i < 4; i++) begin
      tick();
      n_checks++;
      if (pc !== exp_seq[i] || valid !== 1'b1) begin
        n_errors++;
        $display("FAIL seq_inc pc=%h valid=%b required pc=%h valid=1", pc, valid, exp_seq[i]);
      end
    end
  endtask

  task automatic test_stall();
    tick();
    n_checks++;
    if (pc !== 32'h10) begin
      n_errors++;
      $display("FAIL reach_0x10 pc=%h required 10", pc);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (pc !== 32'h10 || en !== 1'b1 || valid !== 1'b1) begin
        n_errors++;
        $display("FAIL stall_hold cyc%0d pc=%h en=%b valid=%b required pc=10 en=1 valid=1", i, pc, en, valid);
      end
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (pc !== 32'h14 || valid !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release pc=%h valid=%b required pc=14 valid=1", pc, valid);
    end
  endtask

  task automatic test_branch();
    tick(); tick(); tick();
    n_checks++;
    if (pc !== 32'h20) begin
      n_errors++;
      $display("FAIL reach_0x20 pc=%h required 20", pc);
    end
    branch = 1'b1; target = 32'h103;
    tick();
    branch = 1'b0;
    n_checks++;
    if (pc !== 32'h100 || valid !== 1'b0) begin
      n_errors++;
      $display("FAIL branch_aligned pc=%h valid=%b required pc=100 valid=0", pc, valid);
    end
    tick();
    n_checks++;
    if (pc !== 32'h104 || valid !== 1'b1) begin
      n_errors++;
      $display("FAIL branch_after pc=%h valid=%b required pc=104 valid=1", pc, valid);
    end
  endtask

  task automatic test_pending();
    branch = 1'b1; target = 32'h40;
    tick();
    n_checks++;
    if (pc !== 32'h40) begin
      n_errors++;
      $display("FAIL reach_0x40 pc=%h required 40", pc);
    end
    stall = 1'b1; target = 32'h80;
    tick();
    target = 32'h90;
    tick();
    branch = 1'b0;
    tick();
    n_checks++;
    if (pc !== 32'h40 || en !== 1'b1) begin
      n_errors++;
      $display("FAIL pend_held pc=%h en=%b required pc=40 en=1", pc, en);
    end
    stall = 1'b0;
    tick();
    n_checks++;
    if (pc !== 32'h90 || valid !== 1'b0) begin
      n_errors++;
      $display("FAIL pend_apply pc=%h valid=%b required pc=90 valid=0", pc, valid);
    end
    tick();
    n_checks++;
    if (pc !== 32'h94 || valid !== 1'b1) begin
      n_errors++;
      $display("FAIL pend_after pc=%h valid=%b required pc=94 valid=1", pc, valid);
    end
  endtask

  task automatic test_exception();
    exc = 1'b1; branch = 1'b1; stall = 1'b1; target = 32'h200;
    tick();
    exc = 1'b0; branch = 1'b0; stall = 1'b0;
    n_checks++;
    if (pc !== 32'h20 || valid !== 1'b0) begin
      n_errors++;
      $display("FAIL exc_priority pc=%h valid=%b required pc=20 valid=0", pc, valid);
    end
    tick();
    n_checks++;
    if (pc !== 32'h24 || valid !== 1'b1) begin
      n_errors++;
      $display("FAIL exc_run pc=%h valid=%b required pc=24 valid=1", pc, valid);
    end
    // Exception while stalled with a buffered branch must discard the buffer
    stall = 1'b1; branch = 1'b1; target = 32'h300;
    tick();
    branch = 1'b0; exc = 1'b1;
    tick();
    exc = 1'b0;
    n_checks++;
    if (pc !== 32'h20) begin
      n_errors++;
      $display("FAIL exc_in_stall pc=%h required 20", pc);
    end
    tick();
    stall = 1'b0;
    tick();
    n_checks++;
    if (pc !== 32'h24 || valid !== 1'b1) begin
      n_errors++;
      $display("FAIL exc_clears_pend pc=%h valid=%b required pc=24 valid=1", pc, valid);
    end
  endtask

  task automatic test_wrap_and_reset();
    logic [7:0] exp_seq [3];
    exp_seq[0] = 8'hF8; exp_seq[1] = 8'hFC; exp_seq[2] = 8'h00;
    n_checks++;
    if (pc8 !== 8'hF8 || en8 !== 1'b0) begin
      n_errors++;
      $display("FAIL w8_reset pc=%h en=%b required pc=f8 en=0", pc8, en8);
    end
    rst8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (pc8 !== exp_seq[i] || valid8 !== 1'b1) begin
        n_errors++;
        $display("FAIL w8_wrap step%0d pc=%h valid=%b required pc=%h valid=1", i, pc8, valid8, exp_seq[i]);
      end
    end
    stall8 = 1'b1; branch8 = 1'b1; target8 = 8'h45;
    tick();
    n_checks++;
    if (pc8 !== 8'h00 || u_dut8.u_buf.o_pend_valid !== 1'b1 || u_dut8.u_buf.o_pend_addr !== 8'h44) begin
      n_errors++;
      $display("FAIL w8_pend_set pc=%h pend_valid=%b pend_addr=%h required pc=00 pend_valid=1 pend_addr=44",
               pc8, u_dut8.u_buf.o_pend_valid, u_dut8.u_buf.o_pend_addr);
    end
    rst8 = 1'b1;
    tick();
    n_checks++;
    if (pc8 !== 8'hF8 || en8 !== 1'b0 || valid8 !== 1'b0 || u_dut8.u_buf.o_pend_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL w8_mid_reset pc=%h en=%b valid=%b pend_valid=%b required pc=f8 en=0 valid=0 pend_valid=0",
               pc8, en8, valid8, u_dut8.u_buf.o_pend_valid);
    end
    rst8 = 1'b0; stall8 = 1'b0; branch8 = 1'b0;
    tick();
    tick();
    n_checks++;
    if (pc8 !== 8'hFC || valid8 !== 1'b1) begin
      n_errors++;
      $display("FAIL w8_no_stale_pend pc=%h valid=%b required pc=fc valid=1", pc8, valid8);
    end
  endtask

  initial begin
    rst8 = 1'b1; stall8 = 1'b0; branch8 = 1'b0; exc8 = 1'b0; target8 = 8'h0;
    test_reset();
    test_stall();
    test_branch();
    test_pending();
    test_exception();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
